// File: rtl/fwd_pkg.sv
// ============================================================================
// fwd_pkg : shared tag type and select helpers for the EX forwarding unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fwd_pkg;

  // Tag rd field is wide enough for any supported register address width
  localparam int TAG_RD_W    = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } tag_t;

  function automatic int stage_to_sel(input int k, input int fwd_stages);
    return fwd_stages + 1 - k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
// ============================================================================
// fwd_hazard_unit_if : ID-side request and EX-side control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fwd_hazard_unit_if #(
  parameter int RW      = 5,
  parameter int NUM_SRC = 2,
  parameter int SW      = 2,
  parameter int CNT_W   = 16
);
  logic                  id_valid;
  logic [NUM_SRC*RW-1:0] id_src;
  logic [NUM_SRC-1:0]    id_src_used;
  logic [RW-1:0]         id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  flush;
  logic                  hold;
  logic                  stall;
  logic [NUM_SRC*SW-1:0] ex_fwd_sel;
  logic [RW-1:0]         ex_rd;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread, flush, hold,
    input  stall, ex_fwd_sel, ex_rd, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread, flush, hold,
    output stall, ex_fwd_sel, ex_rd, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/fwd_match.sv
// ============================================================================
// fwd_match : one tag-versus-address comparator with XZR and load qualification
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_match
  import fwd_pkg::*;
#(
  parameter int RW             = 5,
  parameter int ZERO_REG       = 31,
  parameter int STAGE          = 1,
  parameter int LOAD_FWD_STAGE = 2,
  parameter bit LOAD_ONLY      = 1'b0
) (
  input  tag_t          tag,
  input  logic [RW-1:0] addr,
  input  logic          used,
  output logic          match
);
  logic hit;

  assign hit = tag.valid && tag.regwrite && used &&
               (tag.rd != TAG_RD_W'(ZERO_REG)) && (tag.rd == TAG_RD_W'(addr));

  // LOAD_ONLY picks out load producers (stall check); otherwise loads are
  // masked until the stage where their data exists.
  generate
    if (LOAD_ONLY) begin : g_load
      assign match = hit && tag.memread;
    end else begin : g_fwd
      assign match = hit && !(tag.memread && (STAGE < LOAD_FWD_STAGE));
    end
  endgenerate
endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// fwd_hazard_unit : EX operand forwarding selects and load-use stall
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int RW             = 5,
  parameter int ZERO_REG       = 31,
  parameter int NUM_SRC        = 2,
  parameter int FWD_STAGES     = 2,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int CNT_W          = 16,
  parameter int SW             = $clog2(FWD_STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  fwd_hazard_unit_if.slave   bus
);
  localparam int NST = LOAD_FWD_STAGE - 1;

  tag_t                  ex_tag;
  logic [NUM_SRC*RW-1:0] ex_src;
  logic [NUM_SRC-1:0]    ex_used;
  tag_t                  pipe [1:FWD_STAGES];
  logic [CNT_W-1:0]      stall_count;
  tag_t                  id_tag;
  logic                  stall_raw;
  logic                  stall;
  logic [NUM_SRC*FWD_STAGES-1:0] fwd_hit;
  logic [NUM_SRC*SW-1:0] fwd_sel;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = 1'b1;
    id_tag.rd       = TAG_RD_W'(bus.id_rd);
    id_tag.regwrite = bus.id_regwrite;
    id_tag.memread  = bus.id_memread;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_tag      <= '0;
      ex_src      <= '0;
      ex_used     <= '0;
      stall_count <= '0;
      for (int k = 1; k <= FWD_STAGES; k++) pipe[k] <= '0;
    end else if (!bus.hold) begin
      pipe[1] <= ex_tag;
      for (int k = 2; k <= FWD_STAGES; k++) pipe[k] <= pipe[k-1];
      if (bus.flush || stall || !bus.id_valid) begin
        ex_tag  <= '0;
        ex_src  <= '0;
        ex_used <= '0;
      end else begin
        ex_tag  <= id_tag;
        ex_src  <= bus.id_src;
        ex_used <= bus.id_src_used;
      end
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

  genvar i, k, s;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      for (k = 1; k <= FWD_STAGES; k++) begin : g_stage
        fwd_match #(
          .RW(RW), .ZERO_REG(ZERO_REG), .STAGE(k),
          .LOAD_FWD_STAGE(LOAD_FWD_STAGE), .LOAD_ONLY(1'b0)
        ) u_match (
          .tag   (pipe[k]),
          .addr  (ex_src[i*RW +: RW]),
          .used  (ex_used[i]),
          .match (fwd_hit[i*FWD_STAGES + k - 1])
        );
      end
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_sel = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      fwd_sel[n*SW +: SW] = SW'(FWD_REGFILE);
      for (int m = FWD_STAGES; m >= 1; m--) begin
        if (fwd_hit[n*FWD_STAGES + m - 1]) fwd_sel[n*SW +: SW] = SW'(stage_to_sel(m, FWD_STAGES));
      end
    end
  end

  generate
    if (NST > 0) begin : g_stall
      logic [NST*NUM_SRC-1:0] load_hit;
      for (s = 0; s < NST; s++) begin : g_ss
        tag_t t;
        if (s == 0) begin : g_ex
          assign t = ex_tag;
        end else begin : g_pipe
          assign t = pipe[s];
        end
        for (i = 0; i < NUM_SRC; i++) begin : g_op
          fwd_match #(
            .RW(RW), .ZERO_REG(ZERO_REG), .STAGE(s),
            .LOAD_FWD_STAGE(LOAD_FWD_STAGE), .LOAD_ONLY(1'b1)
          ) u_match (
            .tag   (t),
            .addr  (bus.id_src[i*RW +: RW]),
            .used  (bus.id_src_used[i]),
            .match (load_hit[s*NUM_SRC + i])
          );
        end
      end
      assign stall_raw = |load_hit;
    end else begin : g_nostall
      assign stall_raw = 1'b0;
    end
  endgenerate

  assign stall           = bus.id_valid && !bus.flush && stall_raw;
  assign bus.stall       = stall;
  assign bus.ex_fwd_sel  = fwd_sel;
  assign bus.ex_rd       = RW'(ex_tag.rd);
  assign bus.stall_count = stall_count;
endmodule

`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding logic.
- Internally tracks destination tags of in-flight instructions from EX through FWD_STAGES later stages.
- Produces independent per-operand forward selects for NUM_SRC operands and a load-use stall.
- Sits beside the ID/EX pipeline registers and drives the EX operand muxes and the PC / IF-ID write enables.

Parameters:
- RW, 5: register address width.
- ZERO_REG, 31: register index that is never forwarded or stalled on (XZR).
- NUM_SRC, 2: source operands per instruction.
- FWD_STAGES, 2: number of post-EX stages that can forward. Stage 1 is EX/MEM; stage 2 is MEM/WB.
- LOAD_FWD_STAGE, 2: first stage from which load data is forwardable. Range 1..FWD_STAGES.
- CNT_W, 16: stall counter width.
- SW, clog2(FWD_STAGES+1): forward select width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- id_valid, in, 1: the ID stage holds a real instruction.
- id_src, in, NUM_SRC*RW: ID source register addresses. Operand i is bits [i*RW +: RW].
- id_src_used, in, NUM_SRC: per-operand "operand is read" flag.
- id_rd, in, RW: ID destination register.
- id_regwrite, in, 1: the ID instruction writes id_rd.
- id_memread, in, 1: the ID instruction is a load.
- flush, in, 1: kill the ID instruction (branch taken).
- hold, in, 1: freeze the whole pipeline (memory wait).
- stall, out, 1: load-use stall. Hold PC and IF/ID; a bubble enters EX.
- ex_fwd_sel, out, NUM_SRC*SW: per-operand forward select for the instruction in EX.
- ex_rd, out, RW: EX-stage destination tag, for debug.
- stall_count, out, CNT_W: saturating count of cycles in which a stall took effect.

Behaviour:
- Tag fields: valid, rd, regwrite, memread. Tag 0 is EX; it also holds the registered src addresses and src_used. pipe[1..FWD_STAGES] hold the post-EX tags.
- Reset (asynchronous): all tags invalid, src regs 0, stall_count 0.
- Reset consequences: ex_fwd_sel = 0 (register file), stall = 0, ex_rd = 0.
- Per clock edge, when hold=0:
  - pipe[1] <= EX tag; pipe[k] <= pipe[k-1]; the last stage is dropped.
  - EX tag <= bubble if flush or stall or !id_valid. Otherwise it loads the ID fields.
- Per clock edge, when hold=1: all tags and the counter are frozen. Outputs stay combinational on the current state.
- Match for operand i at stage k (k in 1..FWD_STAGES), all conditions required:
  - pipe[k].valid and pipe[k].regwrite;
  - pipe[k].rd != ZERO_REG;
  - pipe[k].rd == ex_src[i] and ex_src_used[i];
  - not (pipe[k].memread and k < LOAD_FWD_STAGE).
- Forward select: ex_fwd_sel[i] = FWD_STAGES+1-k for the lowest matching k (youngest producer wins). It is 0 if there is no match.
  - For the defaults: EX/MEM = 2'b10, MEM/WB = 2'b01, regfile = 2'b00.
- Operands are fully independent. A match on operand 0 never suppresses operand 1.
- Stall is combinational. stall = 1 iff all of the following hold:
  - id_valid and !flush;
  - some used operand i and some tag s in {EX, pipe[1..LOAD_FWD_STAGE-2]} match;
  - that tag is valid, regwrite, memread, with rd == id_src[i] and rd != ZERO_REG.
  - With the defaults this reduces to a load in EX matching an ID source.
- Stall length: with the defaults, a stall lasts exactly 1 cycle per load-use pair. In general it lasts LOAD_FWD_STAGE-1-s cycles.
- flush overrides stall: stall = 0 and a bubble enters EX.
- stall_count increments on cycles with stall=1 and hold=0. It saturates at all-ones and does not wrap.
- Reset mid-stall: stall drops immediately (asynchronously) because the tags are cleared.

Decomposition:
- Shared package fwd_pkg holds:
  - the tag struct typedef (valid, rd, regwrite, memread);
  - constant FWD_REGFILE = 0;
  - a function stage_to_sel(k).
- One sub-module, fwd_match: a combinational tag-vs-address comparator with the ZERO_REG and load-stage qualification. It is instantiated per (operand, stage) pair and reused for the stall check.

Test Plan:
- ADD X1 followed by SUB using X1 on both operands -> next cycle both ex_fwd_sel fields = 2'b10; stall = 0.
- ADD X2, then a NOP, then a consumer with Rm = X2 -> ex_fwd_sel[1] = 2'b01 and ex_fwd_sel[0] = 0.
- ADD X3 then ADD X3 (again), then a consumer of X3 -> select 2'b10 (youngest wins), not 2'b01.
- LDUR X4 followed immediately by ADD using X4:
  - stall = 1 for exactly 1 cycle and a bubble enters EX;
  - the consumer then sees select 2'b01;
  - stall_count = 1.
- Producer and consumer both using X31 (XZR) -> selects 0 and stall 0.
- Load-use with flush=1 in the same cycle -> stall 0 and EX bubble.
- Load-use with hold=1 for 3 cycles -> stall stays 1 throughout, the counter does not increment, and the tags are unchanged.
- Assert reset mid-stall -> stall, selects and stall_count are 0 immediately.
- Force stall_count to all-ones and trigger another stall -> the counter stays at all-ones.
